// File: rtl/trigger_event_sequencer.sv
// Serialises a trigger bitmap into one timestamped event per set bit, lowest index first.
// First event two cycles after the strobe, one event per two cycles; strobes arriving while busy are dropped and counted.
module trigger_event_sequencer #(
    parameter int DIN_WIDTH = 32,
    parameter int IDX_WIDTH = $clog2(DIN_WIDTH),
    parameter int TS_WIDTH  = 48,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIN_WIDTH-1:0] trig_bits,
    input  logic [TS_WIDTH-1:0]  trig_ts,
    input  logic                 trig_valid,
    output logic                 trig_ready,
    output logic [IDX_WIDTH-1:0] evt_index,
    output logic [TS_WIDTH-1:0]  evt_ts,
    output logic                 evt_last,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [DIN_WIDTH-1:0]   pending;
    logic [TS_WIDTH-1:0]    ts_r;
    logic [IDX_WIDTH-1:0]   lsb_idx;
    logic                   single_bit;
    logic                   accept;
    logic                   do_scan;
    logic                   evt_hs;
    logic                   drop;

    always_comb begin
        lsb_idx = '0;
        for (int i = DIN_WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lsb_idx = IDX_WIDTH'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign single_bit = ((pending & (pending - DIN_WIDTH'(1))) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                state_nxt = PRESENT;
            end
            PRESENT: begin
                if (evt_hs) begin
                    state_nxt = evt_last ? IDLE : SCAN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        trig_ready = (state == IDLE);
        busy       = (state != IDLE);
        accept     = (state == IDLE) && trig_valid && (|trig_bits);
        do_scan    = (state == SCAN);
        evt_hs     = (state == PRESENT) && evt_valid && evt_ready;
        drop       = (state != IDLE) && trig_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            ts_r       <= '0;
            evt_index  <= '0;
            evt_ts     <= '0;
            evt_last   <= 1'b0;
            evt_valid  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (accept) begin
                pending <= trig_bits;
                ts_r    <= trig_ts;
            end else if (evt_hs) begin
                pending[evt_index] <= 1'b0;
            end

            if (do_scan) begin
                evt_index <= lsb_idx;
                evt_ts    <= ts_r;
                evt_last  <= single_bit;
                evt_valid <= 1'b1;
            end else if (evt_hs) begin
                evt_valid <= 1'b0;
            end

            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_trigger_event_sequencer.sv
// Scoreboard bench: expected events queued at each accepted bitmap, checked at every handshake.
module tb_trigger_event_sequencer;

    localparam int DW = 32;
    localparam int IW = 5;
    localparam int TW = 48;
    localparam int CW = 2;

    typedef struct {
        logic [IW-1:0] idx;
        logic [TW-1:0] ts;
        logic          last;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] trig_bits = '0;
    logic [TW-1:0] trig_ts = '0;
    logic          trig_valid = 1'b0;
    logic          trig_ready;
    logic [IW-1:0] evt_index;
    logic [TW-1:0] evt_ts;
    logic          evt_last;
    logic          evt_valid;
    logic          evt_ready = 1'b1;
    logic          busy;
    logic [CW-1:0] drop_count;

    int  checks = 0;
    int  fails = 0;
    int  ev_seen = 0;
    int  drop_exp = 0;
    ev_t sb[$];
    ev_t mon_e;

    always #5 clk = ~clk;

    trigger_event_sequencer #(
        .DIN_WIDTH(DW), .IDX_WIDTH(IW), .TS_WIDTH(TW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .trig_bits(trig_bits), .trig_ts(trig_ts), .trig_valid(trig_valid),
        .trig_ready(trig_ready),
        .evt_index(evt_index), .evt_ts(evt_ts), .evt_last(evt_last),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .busy(busy), .drop_count(drop_count)
    );

    // Handshake monitor: every accepted event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL evt_unexpected: got idx=%0d ts=%h last=%b, required no event", evt_index, evt_ts, evt_last);
            end else begin
                mon_e = sb.pop_front();
                if (evt_index !== mon_e.idx || evt_ts !== mon_e.ts || evt_last !== mon_e.last) begin
                    fails++;
                    $display("FAIL evt_data: got idx=%0d ts=%h last=%b, required idx=%0d ts=%h last=%b",
                             evt_index, evt_ts, evt_last, mon_e.idx, mon_e.ts, mon_e.last);
                end
                ev_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bitmap(input logic [DW-1:0] bits, input logic [TW-1:0] ts);
        int  hi;
        ev_t e;
        hi = -1;
        for (int i = 0; i < DW; i++) if (bits[i]) hi = i;
        for (int i = 0; i < DW; i++) begin
            if (bits[i]) begin
                e.idx  = IW'(i);
                e.ts   = ts;
                e.last = (i == hi);
                sb.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic [DW-1:0] bits, input logic [TW-1:0] ts);
        trig_bits  = bits;
        trig_ts    = ts;
        trig_valid = 1'b1;
        push_bitmap(bits, ts);
        tick();
        trig_valid = 1'b0;
    endtask

    task automatic drop_inc();
        if (drop_exp < (1 << CW) - 1) drop_exp++;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!(trig_ready && sb.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!(trig_ready && sb.size() == 0)) begin
            fails++;
            $display("FAIL %s_timeout: trig_ready=%b pending_events=%0d, required idle with none", name, trig_ready, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL rst_evt_valid: got %b required 0", evt_valid); end
        checks++; if (evt_index !== '0) begin fails++; $display("FAIL rst_evt_index: got %0d required 0", evt_index); end
        checks++; if (evt_ts !== '0) begin fails++; $display("FAIL rst_evt_ts: got %h required 0", evt_ts); end
        checks++; if (evt_last !== 1'b0) begin fails++; $display("FAIL rst_evt_last: got %b required 0", evt_last); end
        checks++; if (drop_count !== '0) begin fails++; $display("FAIL rst_drop: got %0d required 0", drop_count); end
        checks++; if (trig_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rst_ready_busy: got %b/%b required 1/0", trig_ready, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drop_exp = 0;
    endtask

    task automatic test_single();
        int seen0;
        seen0 = ev_seen;
        evt_ready = 1'b1;
        drive(32'h0000_0100, 48'h1234);
        checks++; if (evt_valid !== 1'b0 || busy !== 1'b1 || trig_ready !== 1'b0) begin
            fails++; $display("FAIL single_scan: got valid=%b busy=%b ready=%b required 0/1/0", evt_valid, busy, trig_ready); end
        tick();
        checks++; if (evt_valid !== 1'b1 || evt_index !== 5'd8) begin
            fails++; $display("FAIL single_latency: got valid=%b idx=%0d required 1/8", evt_valid, evt_index); end
        tick();
        checks++; if (trig_ready !== 1'b1 || evt_valid !== 1'b0) begin
            fails++; $display("FAIL single_ready: got ready=%b valid=%b required 1/0", trig_ready, evt_valid); end
        checks++; if (ev_seen - seen0 !== 1) begin fails++; $display("FAIL single_count: got %0d required 1", ev_seen - seen0); end
    endtask

    task automatic test_multi_order();
        int busy_cyc;
        int n;
        int seen0;
        seen0 = ev_seen;
        busy_cyc = 0;
        n = 0;
        drive(32'h8000_0005, 48'hABCD);
        while (busy && n < 40) begin
            busy_cyc++;
            tick();
            n++;
        end
        checks++; if (busy_cyc !== 6) begin fails++; $display("FAIL multi_busy: got %0d cycles required 6", busy_cyc); end
        checks++; if (ev_seen - seen0 !== 3) begin fails++; $display("FAIL multi_count: got %0d required 3", ev_seen - seen0); end
        wait_idle(10, "multi");
    endtask

    task automatic test_backpressure();
        int seen0;
        seen0 = ev_seen;
        evt_ready = 1'b0;
        drive(32'h0000_0003, 48'h0042);
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_index !== 5'd0 || evt_last !== 1'b0 || evt_ts !== 48'h0042) begin
                fails++;
                $display("FAIL bp_hold: cycle %0d got valid=%b idx=%0d last=%b required 1/0/0", c, evt_valid, evt_index, evt_last);
            end
            tick();
        end
        evt_ready = 1'b1;
        wait_idle(20, "bp");
        checks++; if (ev_seen - seen0 !== 2) begin fails++; $display("FAIL bp_count: got %0d required 2", ev_seen - seen0); end
    endtask

    task automatic test_zero_boundary();
        int n;
        int seen0;
        evt_ready = 1'b1;
        trig_bits = '0;
        trig_ts = 48'h9999;
        trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        checks++; if (trig_ready !== 1'b1 || busy !== 1'b0 || drop_count !== CW'(drop_exp)) begin
            fails++; $display("FAIL zero_idle: got ready=%b busy=%b drop=%0d required 1/0/%0d", trig_ready, busy, drop_count, drop_exp); end
        tick();
        tick();
        checks++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL zero_noevt: got valid=%b required 0", evt_valid); end

        seen0 = ev_seen;
        drive(32'hFFFF_FFFF, 48'hFEED_0000_0001);
        n = 0;
        while (!(evt_valid && evt_last) && n < 100) begin
            tick();
            n++;
        end
        // Strobe lands on the same edge as the final handshake: still PRESENT, so it counts as a drop.
        trig_bits = 32'h0000_0001;
        trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        drop_inc();
        checks++; if (drop_count !== CW'(drop_exp) || trig_ready !== 1'b1) begin
            fails++; $display("FAIL final_hs_drop: got drop=%0d ready=%b required %0d/1", drop_count, trig_ready, drop_exp); end
        checks++; if (ev_seen - seen0 !== 32) begin fails++; $display("FAIL full_count: got %0d required 32", ev_seen - seen0); end
        tick();
        tick();
        checks++; if (evt_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL final_hs_ignored: got valid=%b busy=%b required 0/0", evt_valid, busy); end
    endtask

    task automatic test_drops_saturation();
        evt_ready = 1'b0;
        drive(32'h0000_0006, 48'h0055);
        for (int s = 0; s < 5; s++) begin
            trig_bits = $urandom;
            trig_ts = {16'h0, $urandom};
            trig_valid = 1'b1;
            tick();
            drop_inc();
        end
        trig_valid = 1'b0;
        checks++; if (drop_count !== CW'(drop_exp) || drop_exp !== 3) begin
            fails++; $display("FAIL drop_sat: got %0d required %0d", drop_count, drop_exp); end
        checks++; if (evt_valid !== 1'b1 || evt_index !== 5'd1 || evt_ts !== 48'h0055) begin
            fails++; $display("FAIL drop_no_disturb: got valid=%b idx=%0d ts=%h required 1/1/55", evt_valid, evt_index, evt_ts); end
        evt_ready = 1'b1;
        wait_idle(20, "drop");
        checks++; if (drop_count !== 2'd3) begin fails++; $display("FAIL drop_hold: got %0d required 3", drop_count); end
    endtask

    task automatic test_reset_mid_drain();
        int stray;
        evt_ready = 1'b0;
        drive(32'h0000_000F, 48'h0077);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        drop_exp = 0;
        checks++; if (evt_valid !== 1'b0 || drop_count !== '0) begin
            fails++; $display("FAIL mid_rst_async: got valid=%b drop=%0d required 0/0", evt_valid, drop_count); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (evt_valid) stray++;
        end
        checks++; if (stray !== 0) begin fails++; $display("FAIL mid_rst_residual: got %0d event cycles required 0", stray); end
        checks++; if (trig_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL mid_rst_ready: got ready=%b busy=%b required 1/0", trig_ready, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_order();
        test_backpressure();
        test_zero_boundary();
        test_drops_saturation();
        test_reset_mid_drain();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d events outstanding required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/trigger_event_sequencer.md
Name: trigger_event_sequencer

Overview:
- Serialises multi-beam FRB trigger bitmaps into one event per set bit, each tagged with the bitmap's timestamp.
- Wraps a registered lowest-set-bit search over a pending-bit register and sequences it: latch, scan, present, clear, repeat.
- Sits between the detection threshold stage and the timestamp/readout FIFO.
- Bitmaps arriving while a previous bitmap is still being drained are dropped and counted.

Parameters:
- DIN_WIDTH, 32, number of trigger lines (bitmap width); must be >= 2.
- IDX_WIDTH, $clog2(DIN_WIDTH), width of the event index.
- TS_WIDTH, 48, timestamp width.
- CNT_WIDTH, 16, width of the dropped-bitmap counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- trig_bits  in  DIN_WIDTH  trigger bitmap; bit i = beam i fired.
- trig_ts  in  TS_WIDTH  timestamp associated with trig_bits.
- trig_valid  in  1  single-cycle strobe; no backpressure to the source.
- trig_ready  out  1  high when a new bitmap will be accepted (state IDLE).
- evt_index  out  IDX_WIDTH  index of the beam being reported.
- evt_ts  out  TS_WIDTH  timestamp latched with the bitmap.
- evt_last  out  1  high on the final event of a bitmap.
- evt_valid  out  1  event available.
- evt_ready  in  1  downstream accepts the event.
- busy  out  1  high whenever state is not IDLE.
- drop_count  out  CNT_WIDTH  bitmaps lost; saturating.

Behaviour:
- Reset (async assert, sync release): state IDLE, pending=0, ts_r=0.
  - Outputs: evt_index=0, evt_ts=0, evt_last=0, evt_valid=0, drop_count=0, trig_ready=1, busy=0.
  - Reset mid-drain discards all pending bits; no partial event survives.
- States are IDLE, SCAN and PRESENT.
- IDLE, trig_valid=1, trig_bits!=0:
  - pending<=trig_bits, ts_r<=trig_ts, go to SCAN.
- IDLE, trig_valid=1, trig_bits==0:
  - Accepted and ignored. No event, no count, stay IDLE.
- SCAN (exactly one cycle):
  - evt_index<=lowest set index of pending (registered encoder).
  - evt_ts<=ts_r.
  - evt_last<=1 if pending has exactly one bit set.
  - evt_valid<=1, go to PRESENT.
- PRESENT:
  - evt_index, evt_ts, evt_last held stable while evt_valid=1 and evt_ready=0.
  - On evt_valid & evt_ready: clear pending[evt_index], evt_valid<=0.
  - If evt_last, go to IDLE; else go to SCAN.
- Latency and throughput:
  - First evt_valid appears 2 cycles after the accepting trig_valid edge.
  - Sustained rate is one event per 2 cycles with evt_ready tied high.
  - A bitmap with K bits returns trig_ready high 2K cycles after acceptance.
- Ordering: events are emitted in strictly ascending index order.
- trig_ready:
  - Combinational: trig_ready = (state==IDLE).
  - It is high in the cycle the FSM returns to IDLE, so a bitmap arriving in the cycle immediately after the last handshake is accepted.
- Drops:
  - trig_valid=1 while state!=IDLE increments drop_count by 1, regardless of trig_bits.
  - Saturates at 2^CNT_WIDTH-1.
  - pending and ts_r are unaffected.
- Simultaneous events: a trig_valid in the same cycle as the final evt handshake is a drop, because state is still PRESENT.
- evt_valid is never deasserted without a handshake, except by reset.

Test Plan:
- Single bit: trig_bits=0x0000_0100, trig_ts=0x1234, evt_ready=1 -> one event two cycles later, index=8, ts=0x1234, last=1; trig_ready high the next cycle.
- Multi-bit ordering: trig_bits=0x8000_0005, ts=0xABCD, evt_ready=1 -> events index 0, 2, 31 every 2 cycles, all ts=0xABCD, last=1 only on 31; busy for 6 cycles.
- Backpressure: trig_bits=0x0000_0003, evt_ready low for 5 cycles -> index=0 held stable for 5 cycles; after ready, index 1 follows; no events lost or repeated.
- Drops and saturation: CNT_WIDTH=2, 5 strobes while busy -> drop_count=3 and stays 3; the drained bitmap's events are unchanged.
- Zero bitmap and boundary: trig_bits=0 -> no event, drop_count unchanged; trig_bits=0xFFFF_FFFF -> 32 events, indices 0..31, last on 31; strobe in the cycle of the final handshake -> drop_count+1.
- Reset mid-drain: assert rst_n=0 during PRESENT of bitmap 0x0F -> evt_valid=0 and drop_count=0 immediately; after release, no residual events and trig_ready=1.
